// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if
// Bundle of the signals crossing the EX/MEM boundary.
//   master : the side that drives the EX results and pipeline controls
//            and observes the MEM-side fields (core / testbench).
//   slave  : the EX/MEM pipeline register itself.
// Control : stall_ex, stall_mem, flush
// EX side : ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
//           ex_aluop, ex_mem_addr, ex_reg2, hilo_tmp_i, cnt_i
// MEM side: mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
//           mem_whilo, mem_aluop, mem_mem_addr, mem_reg2
// Feedback: hilo_tmp_o, cnt_o (to EX), bubble_cnt (performance)
interface ex_mem_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) ();
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush;

    logic                  ex_valid;
    logic [REG_AW-1:0]     ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic                  ex_whilo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [2*DATA_W-1:0]   hilo_tmp_i;
    logic [CNT_W-1:0]      cnt_i;

    logic                  mem_valid;
    logic [REG_AW-1:0]     mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic                  mem_whilo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [2*DATA_W-1:0]   hilo_tmp_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [PERF_W-1:0]     bubble_cnt;

    modport master (
        output stall_ex, stall_mem, flush,
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        output ex_aluop, ex_mem_addr, ex_reg2, hilo_tmp_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
        input  mem_whilo, mem_aluop, mem_mem_addr, mem_reg2,
        input  hilo_tmp_o, cnt_o, bubble_cnt
    );

    modport slave (
        input  stall_ex, stall_mem, flush,
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
        input  ex_aluop, ex_mem_addr, ex_reg2, hilo_tmp_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
        output mem_whilo, mem_aluop, mem_mem_addr, mem_reg2,
        output hilo_tmp_o, cnt_o, bubble_cnt
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
// EX/MEM pipeline register with stall, bubble insertion, flush, a valid
// bit, load/store side-band fields, carry-through of the multi-cycle
// multiply-accumulate state and a saturating bubble counter.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : ex_mem_pipe_if.slave (controls, EX inputs, MEM outputs,
//         hilo_tmp/cnt feedback, bubble_cnt)
// Per-cycle priority: reset > flush > hold (stall_mem) > bubble
// (stall_ex) > advance. All outputs come straight from registers.
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_pipe_if.slave  bus
);
    // MEM-side instruction fields travel together as one record so that
    // NOP loading and advancing stay in step.
    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   wd;
        logic                wreg;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic                whilo;
        logic [ALUOP_W-1:0]  aluop;
        logic [DATA_W-1:0]   mem_addr;
        logic [DATA_W-1:0]   reg2;
    } stage_t;

    localparam logic [PERF_W-1:0] BUB_MAX = '1;

    stage_t               stage_reg,    stage_next;
    logic [2*DATA_W-1:0]  hilo_tmp_reg, hilo_tmp_next;
    logic [CNT_W-1:0]     cnt_reg,      cnt_next;
    logic [PERF_W-1:0]    bubble_reg,   bubble_next;
    stage_t               ex_stage;

    always_comb begin
        ex_stage.valid    = bus.ex_valid;
        ex_stage.wd       = bus.ex_wd;
        ex_stage.wreg     = bus.ex_wreg;
        ex_stage.wdata    = bus.ex_wdata;
        ex_stage.hi       = bus.ex_hi;
        ex_stage.lo       = bus.ex_lo;
        ex_stage.whilo    = bus.ex_whilo;
        ex_stage.aluop    = bus.ex_aluop;
        ex_stage.mem_addr = bus.ex_mem_addr;
        ex_stage.reg2     = bus.ex_reg2;
    end

    always_comb begin
        stage_next    = stage_reg;
        hilo_tmp_next = hilo_tmp_reg;
        cnt_next      = cnt_reg;
        bubble_next   = bubble_reg;
        if (bus.flush) begin
            // Discard everything, including a partially computed
            // multi-cycle op; the perf counter is not a bubble.
            stage_next    = '0;
            hilo_tmp_next = '0;
            cnt_next      = '0;
        end else if (bus.stall_mem) begin
            // Hold: defaults already keep every register.
        end else if (bus.stall_ex) begin
            // Bubble: NOP downstream, but keep EX's iteration state so it
            // can continue the multi-cycle op next cycle.
            stage_next    = '0;
            hilo_tmp_next = bus.hilo_tmp_i;
            cnt_next      = bus.cnt_i;
            if (bubble_reg != BUB_MAX) begin
                bubble_next = bubble_reg + 1'b1;
            end
        end else begin
            // Advance: the multi-cycle op (if any) has completed.
            stage_next    = ex_stage;
            hilo_tmp_next = '0;
            cnt_next      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg    <= '0;
            hilo_tmp_reg <= '0;
            cnt_reg      <= '0;
            bubble_reg   <= '0;
        end else begin
            stage_reg    <= stage_next;
            hilo_tmp_reg <= hilo_tmp_next;
            cnt_reg      <= cnt_next;
            bubble_reg   <= bubble_next;
        end
    end

    assign bus.mem_valid    = stage_reg.valid;
    assign bus.mem_wd       = stage_reg.wd;
    assign bus.mem_wreg     = stage_reg.wreg;
    assign bus.mem_wdata    = stage_reg.wdata;
    assign bus.mem_hi       = stage_reg.hi;
    assign bus.mem_lo       = stage_reg.lo;
    assign bus.mem_whilo    = stage_reg.whilo;
    assign bus.mem_aluop    = stage_reg.aluop;
    assign bus.mem_mem_addr = stage_reg.mem_addr;
    assign bus.mem_reg2     = stage_reg.reg2;
    assign bus.hilo_tmp_o   = hilo_tmp_reg;
    assign bus.cnt_o        = cnt_reg;
    assign bus.bubble_cnt   = bubble_reg;
endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline register for the five-stage core. It supersedes the fixed 32-bit stage latch. It adds:
- pipeline control: stall, bubble insertion and flush;
- a valid bit;
- load/store side-band fields;
- carry-through of the multi-cycle multiply-accumulate state (`hilo_tmp`/`cnt`);
- a saturating bubble counter for performance monitoring.

It sits between the execute stage and the memory-access stage. It is driven by the stall controller's per-stage stall lines and its flush line.

## Interface
Parameters:
- `DATA_W`, 32, width of data, HI, LO, address and store-data fields
- `REG_AW`, 5, register-file address width
- `ALUOP_W`, 8, ALU opcode width forwarded to MEM
- `CNT_W`, 2, multi-cycle iteration counter width
- `PERF_W`, 16, bubble counter width

Ports:
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-low reset
- `stall_ex` in 1, EX stage stalled this cycle
- `stall_mem` in 1, MEM stage stalled this cycle
- `flush` in 1, discard stage contents (exception/redirect)
- `ex_valid` in 1, EX holds a real instruction
- `ex_wd` in REG_AW, destination register
- `ex_wreg` in 1, register write enable
- `ex_wdata` in DATA_W, result
- `ex_hi`, `ex_lo` in DATA_W, HI/LO results
- `ex_whilo` in 1, HI/LO write enable
- `ex_aluop` in ALUOP_W, opcode for MEM
- `ex_mem_addr` in DATA_W, load/store address
- `ex_reg2` in DATA_W, store data
- `hilo_tmp_i` in 2*DATA_W, partial MADD/MSUB product from EX
- `cnt_i` in CNT_W, EX iteration count
- `mem_valid` out 1; `mem_wd` out REG_AW; `mem_wreg` out 1; `mem_wdata` out DATA_W
- `mem_hi` out DATA_W; `mem_lo` out DATA_W; `mem_whilo` out 1
- `mem_aluop` out ALUOP_W; `mem_mem_addr` out DATA_W; `mem_reg2` out DATA_W
- `hilo_tmp_o` out 2*DATA_W, fed back to EX
- `cnt_o` out CNT_W, fed back to EX
- `bubble_cnt` out PERF_W, count of inserted bubbles

## Operation
All outputs are registered. Each cycle exactly one action applies, in priority order:
1. **Reset** (`rst`=0, asynchronous):
   - Every output goes to 0.
   - `mem_wd`=0 (NOP register), `mem_wreg`=`mem_whilo`=0, `mem_valid`=0, `bubble_cnt`=0.
2. **Flush** (`flush`=1):
   - Load a NOP: `mem_valid`, `mem_wreg`, `mem_whilo`, `mem_wd`, `mem_aluop` and all data fields go to 0.
   - `hilo_tmp_o`=0, `cnt_o`=0.
   - `bubble_cnt` unchanged.
   - Flush overrides both stall inputs.
3. **Hold** (`stall_mem`=1):
   - All outputs keep their value, including `hilo_tmp_o`/`cnt_o`.
   - This applies regardless of `stall_ex`.
4. **Bubble** (`stall_ex`=1, `stall_mem`=0):
   - Load a NOP into the mem_* fields, as in flush.
   - Capture `hilo_tmp_o`←`hilo_tmp_i` and `cnt_o`←`cnt_i`, so EX can iterate a multi-cycle op.
   - `bubble_cnt` increments, saturating at 2^PERF_W−1.
5. **Advance** (`stall_ex`=0, `stall_mem`=0):
   - mem_* ← ex_* and `mem_valid`←`ex_valid`.
   - `hilo_tmp_o`←0 and `cnt_o`←0, because the multi-cycle op has completed.

Further rules:
- **Invalid input:** when `ex_valid`=0 on advance, write enables still propagate as presented. EX is required to drive `ex_wreg`=`ex_whilo`=0 for invalid slots; the block does not mask them.
- **Width handling:** there is no arithmetic on datapath fields, so widths pass straight through. `bubble_cnt` is an unsigned saturating counter.

## Timing
- Latency is 1 cycle: EX values presented before rising edge N appear on the mem_* outputs after edge N.
- No combinational path from any input to any output.
- Reset acts immediately on assertion with no clock edge. Release is synchronous to the next rising edge; the first capture happens on the first edge with `rst`=1.
- Reset asserted during a multi-cycle op clears `hilo_tmp_o`/`cnt_o`, and the op is lost.
- `flush` and `stall_mem` high together: flush wins and the outputs become a NOP.
- `flush` is single-cycle. Holding it high keeps the NOP loaded every cycle.
- Bubble counter at saturation stays at its maximum through further bubbles. Only reset clears it.
- A multi-cycle op occupies N bubble cycles (`cnt_o` sequence 1,2,…) and then one advance cycle. On the advance cycle `mem_hi`/`mem_lo` take the final EX result and `cnt_o` returns to 0.

## Test plan
- **Reset mid-stream:** drive `ex_wdata`=0x1234_5678, `ex_wreg`=1, `ex_wd`=5, then pull `rst` low between edges. All outputs must be 0 immediately; after release, the first advance edge must give `mem_wdata`=0x1234_5678 and `mem_wd`=5.
- **Advance pipeline:** give three consecutive instructions with `ex_wdata`=1, 2, 3 and all controls idle. `mem_wdata` must read 1, 2, 3 on consecutive cycles with `mem_valid`=1.
- **Bubble plus multi-cycle:** hold `stall_ex`=1 for 2 cycles, with `hilo_tmp_i`=0x0000_0001_0000_0002 and `cnt_i`=1 then 2. Required:
  - `mem_valid`=0 and `mem_wreg`=0 during the stall;
  - `cnt_o` reads 1 then 2;
  - `bubble_cnt` goes 0→2;
  - on the release cycle, `cnt_o`=0 and `hilo_tmp_o`=0.
- **Hold:** with `mem_wdata`=0xAA, set `stall_mem`=`stall_ex`=1 and change the EX inputs to 0xBB for 3 cycles. Outputs must stay 0xAA and `bubble_cnt` must stay unchanged.
- **Flush priority:** assert `flush`, `stall_mem` and `stall_ex` together with valid EX data. The next edge must give `mem_valid`=0, `mem_wreg`=0, `cnt_o`=0, and `bubble_cnt` unchanged.
- **Saturation:** with `PERF_W`=4, apply 20 bubble cycles. `bubble_cnt` must stop at 15.
